// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter/mux: command codes placed on
// {cs_n,ras_n,cas_n,we_n}, one-hot state encodings, and the write/read
// round-robin marker type used when SDRAM_RR_EN is defined.
package sdram_pkg;

  // SDRAM command codes, ordered {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;

  // One-hot state encodings
  localparam int STATE_W = 5;
  localparam logic [STATE_W-1:0] ST_IDLE_OH  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_ARBIT_OH = 5'b00010;
  localparam logic [STATE_W-1:0] ST_AREF_OH  = 5'b00100;
  localparam logic [STATE_W-1:0] ST_WRITE_OH = 5'b01000;
  localparam logic [STATE_W-1:0] ST_READ_OH  = 5'b10000;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE_OH,
    S_ARBIT = ST_ARBIT_OH,
    S_AREF  = ST_AREF_OH,
    S_WRITE = ST_WRITE_OH,
    S_READ  = ST_READ_OH
  } state_t;

  // Which of write/read was granted last (round-robin bookkeeping)
  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_t;

endpackage

// File: rtl/sdram_arb_mux.sv
// SDRAM bus arbiter/mux. After the init client finishes, grants one of the
// refresh/write/read clients at a time and muxes its command, address and
// bank onto the pads. Drives DQ only while writing and registers DQ every
// cycle for the read client. A watchdog aborts write/read grants that run
// for GRANT_MAX cycles and latches wdog_err until reset.
// Optional feature: define SDRAM_RR_EN to alternate write/read grants when
// both ask together; otherwise write always beats read.
module sdram_arb_mux
  import sdram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BANK_W    = 2,
  parameter int DQ_W      = 16,
  parameter int GRANT_MAX = 1023
) (
  input  logic              sclk,
  input  logic              srst_n,
  // init client
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  // refresh client
  input  logic              aref_ask,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  // write client
  input  logic              wr_ask,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [DQ_W-1:0]   wr_data,
  output logic              wr_en,
  // read client
  input  logic              rd_ask,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BANK_W-1:0] rd_bank,
  output logic              rd_en,
  output logic [DQ_W-1:0]   rd_data,
  // status
  output logic              wdog_err,
  // SDRAM pads
  output logic              sdram_clk,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BANK_W-1:0] sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W/8-1:0] sdram_dqm,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  localparam int CNT_W = $clog2(GRANT_MAX + 1);
  // Count value seen during the GRANT_MAX-th cycle of a grant
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_MAX - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  grant_cnt_reg;
  logic              grant_done;
  logic              wdog_trip;
  logic              wr_pick;
  logic              dq_oe;
  logic [3:0]        pin_cmd;

  // Write wins the write/read decision in ARBIT when wr_pick is high
`ifdef SDRAM_RR_EN
  rr_t rr_last_reg;

  assign wr_pick = wr_ask && (!rd_ask || (rr_last_reg == RR_READ));

  // Remember which of write/read got the last grant
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      rr_last_reg <= RR_READ;
    end else if (state_reg == S_ARBIT && !aref_ask && (wr_ask || rd_ask)) begin
      rr_last_reg <= wr_pick ? RR_WRITE : RR_READ;
    end
  end
`else
  assign wr_pick = wr_ask;
`endif

  assign grant_done = (grant_cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: every grant ends back in ARBIT for at least one NOP
  always_comb begin
    state_next = state_reg;
    wdog_trip  = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (init_end) state_next = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_ask)     state_next = S_AREF;
        else if (wr_pick) state_next = S_WRITE;
        else if (rd_ask)  state_next = S_READ;
      end
      S_AREF: begin
        if (aref_end) state_next = S_ARBIT;
      end
      S_WRITE: begin
        if (wr_end) begin
          state_next = S_ARBIT;
        end else if (grant_done) begin
          state_next = S_ARBIT;
          wdog_trip  = 1'b1;
        end
      end
      S_READ: begin
        if (rd_end) begin
          state_next = S_ARBIT;
        end else if (grant_done) begin
          state_next = S_ARBIT;
          wdog_trip  = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grant length counter: zero outside write/read, counts up inside
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      grant_cnt_reg <= '0;
    end else if (state_reg == S_WRITE || state_reg == S_READ) begin
      grant_cnt_reg <= grant_cnt_reg + 1'b1;
    end else begin
      grant_cnt_reg <= '0;
    end
  end

  // Sticky watchdog flag, cleared only by reset
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      wdog_err <= 1'b0;
    end else if (wdog_trip) begin
      wdog_err <= 1'b1;
    end
  end

  // Capture the DQ bus every cycle; the read client aligns CAS latency
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= sdram_dq;
    end
  end

  // Pad mux and grant outputs, decoded from the current state only
  always_comb begin
    pin_cmd    = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    aref_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    dq_oe      = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        pin_cmd    = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        pin_cmd    = aref_cmd;
        sdram_addr = aref_addr;
        aref_en    = 1'b1;
      end
      S_WRITE: begin
        pin_cmd    = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
        wr_en      = ~aref_ask;
        dq_oe      = 1'b1;
      end
      S_READ: begin
        pin_cmd    = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
        rd_en      = ~aref_ask;
      end
      default: begin
        pin_cmd = CMD_NOP;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;
  assign sdram_dq  = dq_oe ? wr_data : {DQ_W{1'bz}};
  assign sdram_clk = ~sclk;
  assign sdram_cke = 1'b1;
  assign sdram_dqm = '0;

endmodule

// File: tb/tb_sdram_arb_mux.sv
// Scoreboard bench for sdram_arb_mux. The driver issues grant requests and
// pushes the expected grant (kind, pins, data) chosen by a priority model;
// a negedge monitor pops and compares whenever a grant enable rises, and
// checks NOP pins between grants. Watchdog uses GRANT_MAX=15.
// Honours SDRAM_RR_EN in its reference model.
module tb_sdram_arb_mux;
  import sdram_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int BANK_W    = 2;
  localparam int DQ_W      = 16;
  localparam int GRANT_MAX = 15;

  logic sclk = 1'b0;
  logic srst_n = 1'b0;
  logic [3:0]        init_cmd = 4'b0000;
  logic [ADDR_W-1:0] init_addr = '0;
  logic              init_end = 1'b0;
  logic aref_ask = 1'b0, aref_end = 1'b0;
  logic [3:0]        aref_cmd = CMD_AREF;
  logic [ADDR_W-1:0] aref_addr = '0;
  logic wr_ask = 1'b0, wr_end = 1'b0;
  logic [3:0]        wr_cmd = CMD_WRITE;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [BANK_W-1:0] wr_bank = '0;
  logic [DQ_W-1:0]   wr_data = '0;
  logic rd_ask = 1'b0, rd_end = 1'b0;
  logic [3:0]        rd_cmd = CMD_READ;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [BANK_W-1:0] rd_bank = '0;
  logic aref_en, wr_en, rd_en, wdog_err;
  logic [DQ_W-1:0]   rd_data;
  logic sdram_clk, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W/8-1:0] sdram_dqm;
  wire  [DQ_W-1:0]   sdram_dq;

  // Memory-side driver of the DQ bus
  logic              dq_oe = 1'b0;
  logic [DQ_W-1:0]   dq_val = '0;
  assign sdram_dq = dq_oe ? dq_val : {DQ_W{1'bz}};

  wire [3:0] pin_cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  sdram_arb_mux #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .GRANT_MAX(GRANT_MAX)
  ) dut (
    .sclk(sclk), .srst_n(srst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_end(init_end),
    .aref_ask(aref_ask), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_addr(aref_addr), .aref_en(aref_en),
    .wr_ask(wr_ask), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .wr_data(wr_data), .wr_en(wr_en),
    .rd_ask(rd_ask), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .rd_en(rd_en), .rd_data(rd_data),
    .wdog_err(wdog_err),
    .sdram_clk(sdram_clk), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dqm(sdram_dqm), .sdram_dq(sdram_dq)
  );

  always #5 sclk = ~sclk;

  int errors = 0;
  int checks = 0;

  typedef enum int { K_AREF = 0, K_WR = 1, K_RD = 2 } kind_e;
  typedef struct {
    kind_e             kind;
    logic [3:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [DQ_W-1:0]   data;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference model: refresh first, then write/read by fixed or alternating priority
  kind_e last_wrrd = K_RD;
  function automatic kind_e pick(input bit a, input bit w, input bit r);
    kind_e k;
    if (a) return K_AREF;
    if (w && r) begin
`ifdef SDRAM_RR_EN
      k = (last_wrrd == K_WR) ? K_RD : K_WR;
`else
      k = K_WR;
`endif
    end else if (w) k = K_WR;
    else k = K_RD;
    last_wrrd = k;
    return k;
  endfunction

  function automatic exp_t expect_for(input kind_e k);
    exp_t e;
    e.kind = k;
    e.data = wr_data;
    case (k)
      K_AREF:  begin e.cmd = aref_cmd; e.addr = aref_addr; e.bank = '0; end
      K_WR:    begin e.cmd = wr_cmd;   e.addr = wr_addr;   e.bank = wr_bank; end
      default: begin e.cmd = rd_cmd;   e.addr = rd_addr;   e.bank = rd_bank; end
    endcase
    return e;
  endfunction

  function automatic logic [3:0] rand_cmd();
    logic [3:0] c;
    c = 4'($urandom_range(0, 15));
    if (c == CMD_NOP) c = CMD_MRS;
    return c;
  endfunction

  task automatic rand_clients();
    aref_cmd = rand_cmd(); aref_addr = ADDR_W'($urandom);
    wr_cmd = rand_cmd(); wr_addr = ADDR_W'($urandom); wr_bank = BANK_W'($urandom);
    wr_data = DQ_W'($urandom);
    rd_cmd = rand_cmd(); rd_addr = ADDR_W'($urandom); rd_bank = BANK_W'($urandom);
  endtask

  // Monitor: pop and compare on each rising grant; NOP pins between grants
  logic mon_en = 1'b0, nop_chk = 1'b0, prev_g = 1'b0, loop_pend = 1'b0, mg;
  logic [DQ_W-1:0] loop_val;
  int   mk;
  exp_t me;
  always @(negedge sclk) begin
    if (mon_en) begin
      if (loop_pend) begin
        chk("wr_loopback_rd_data", 32'(rd_data), 32'(loop_val));
        loop_pend = 1'b0;
      end
      mg = aref_en | wr_en | rd_en;
      if (mg && !prev_g) begin
        mk = aref_en ? 0 : (wr_en ? 1 : 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant_kind", 32'(mk), 32'hFFFF_FFFF);
        end else begin
          me = exp_q.pop_front();
          chk("grant_kind", 32'(mk), 32'(me.kind));
          chk("grant_cmd", 32'(pin_cmd), 32'(me.cmd));
          chk("grant_addr", 32'(sdram_addr), 32'(me.addr));
          chk("grant_bank", 32'(sdram_bank), 32'(me.bank));
          if (me.kind == K_WR) begin
            chk("wr_dq_driven", 32'(sdram_dq), 32'(me.data));
            loop_pend = 1'b1;
            loop_val  = me.data;
          end
        end
        $display("grant kind=%0d cmd=%b addr=%h bank=%0d", mk, pin_cmd, sdram_addr, sdram_bank);
      end else if (!mg && nop_chk) begin
        chk("arbit_nop_pins", {16'h0, pin_cmd, sdram_bank, 10'h0}, {16'h0, CMD_NOP, 2'b00, 10'h0});
        chk("arbit_nop_addr", 32'(sdram_addr), 32'h0);
      end
      prev_g = mg;
    end else begin
      prev_g = 1'b0;
    end
  end

  // One grant: all chosen clients ask together in ARBIT, winner holds for 'hold' cycles
  task automatic txn(input bit a, input bit w, input bit r, input int hold, input bit stray);
    kind_e k;
    bit held, rd_ok;
    rand_clients();
    k = pick(a, w, r);
    exp_q.push_back(expect_for(k));
    aref_ask = a; wr_ask = w; rd_ask = r;
    @(posedge sclk); #1;
    aref_ask = 1'b0; wr_ask = 1'b0; rd_ask = 1'b0;
    held = 1'b1; rd_ok = 1'b1;
    for (int i = 1; i < hold; i++) begin
      if (k == K_RD) begin dq_oe = 1'b1; dq_val = DQ_W'($urandom); end
      if (stray && i == 1) begin
        aref_end = (k != K_AREF); wr_end = (k != K_WR); rd_end = (k != K_RD);
      end
      @(negedge sclk);
      if (!(k == K_AREF ? aref_en : (k == K_WR ? wr_en : rd_en))) held = 1'b0;
      @(posedge sclk); #1;
      aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
      if (k == K_RD && rd_data !== dq_val) rd_ok = 1'b0;
    end
    aref_end = (k == K_AREF); wr_end = (k == K_WR); rd_end = (k == K_RD);
    @(negedge sclk);
    if (!(k == K_AREF ? aref_en : (k == K_WR ? wr_en : rd_en))) held = 1'b0;
    @(posedge sclk); #1;
    aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    dq_oe = 1'b0;
    chk("grant_held_until_end", 32'(held), 32'd1);
    if (k == K_RD && hold > 1) chk("rd_data_capture", 32'(rd_ok), 32'd1);
    $display("txn ask=%b%b%b winner=%0d hold=%0d", a, w, r, k, hold);
  endtask

  int wd_cycles;

  initial begin
    // Reset state
    init_cmd = 4'b1010; init_addr = 12'h3C5;
    repeat (3) @(posedge sclk);
    #1;
    chk("reset_pins_init_cmd", 32'(pin_cmd), 32'(4'b1010));
    chk("reset_addr_init_addr", 32'(sdram_addr), 32'h3C5);
    chk("reset_grants", {29'h0, aref_en, wr_en, rd_en}, 32'h0);
    chk("reset_wdog_err", 32'(wdog_err), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("cke_dqm", {15'h0, sdram_cke, 14'h0, sdram_dqm}, {15'h0, 1'b1, 16'h0});
    srst_n = 1'b1;
    mon_en = 1'b1;

    // Init phase: pins follow init client; stray asks/ends ignored
    for (int c = 1; c <= 200; c++) begin
      init_cmd  = 4'($urandom);
      init_addr = ADDR_W'($urandom);
      aref_ask  = (c < 200) && ($urandom_range(0, 7) == 0);
      wr_ask    = (c < 200) && ($urandom_range(0, 7) == 0);
      wr_end    = (c < 200) && ($urandom_range(0, 7) == 0);
      init_end  = (c == 200);
      @(negedge sclk);
      chk("idle_pins", {pin_cmd, sdram_bank, sdram_addr}, {init_cmd, 2'b00, init_addr});
      @(posedge sclk); #1;
    end
    init_end = 1'b0; aref_ask = 1'b0; wr_ask = 1'b0; wr_end = 1'b0;
    nop_chk = 1'b1;
    @(posedge sclk); #1;

    // Refresh beats write; write follows after refresh end and one NOP
    rand_clients();
    exp_q.push_back(expect_for(pick(1'b1, 1'b1, 1'b0)));
    exp_q.push_back(expect_for(pick(1'b0, 1'b1, 1'b0)));
    aref_ask = 1'b1; wr_ask = 1'b1;
    @(posedge sclk); #1; aref_ask = 1'b0;
    @(posedge sclk); #1; aref_end = 1'b1;
    @(posedge sclk); #1; aref_end = 1'b0;
    @(posedge sclk); #1; wr_ask = 1'b0;
    wr_end = 1'b1;
    @(posedge sclk); #1; wr_end = 1'b0;
    $display("txn aref+wr same cycle: AREF then WRITE");

    // Write and read held together for four grants
    rand_clients();
    for (int i = 0; i < 4; i++) exp_q.push_back(expect_for(pick(1'b0, 1'b1, 1'b1)));
    wr_ask = 1'b1; rd_ask = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge sclk); #1; wr_end = 1'b1; rd_end = 1'b1;
      @(posedge sclk); #1; wr_end = 1'b0; rd_end = 1'b0;
      $display("txn wr+rd held grant %0d", i);
    end
    wr_ask = 1'b0; rd_ask = 1'b0;
    @(posedge sclk); #1;

    // Refresh request during a write drops wr_en, then refresh follows
    rand_clients();
    exp_q.push_back(expect_for(pick(1'b0, 1'b1, 1'b0)));
    exp_q.push_back(expect_for(pick(1'b1, 1'b0, 1'b0)));
    wr_ask = 1'b1;
    @(posedge sclk); #1; wr_ask = 1'b0;
    @(negedge sclk);
    chk("wr_en_granted", 32'(wr_en), 32'd1);
    @(posedge sclk); #1; nop_chk = 1'b0; aref_ask = 1'b1;
    @(negedge sclk);
    chk("wr_en_low_aref_pending", 32'(wr_en), 32'd0);
    chk("write_pins_kept", 32'(pin_cmd), 32'(wr_cmd));
    @(posedge sclk); #1; wr_end = 1'b1;
    @(posedge sclk); #1; wr_end = 1'b0; nop_chk = 1'b1;
    @(posedge sclk); #1; aref_ask = 1'b0; aref_end = 1'b1;
    @(posedge sclk); #1; aref_end = 1'b0;
    $display("txn aref during write: WRITE then AREF");

    // End on the last allowed cycle is a plain end
    txn(1'b0, 1'b0, 1'b1, GRANT_MAX, 1'b0);
    chk("end_at_limit_no_wdog", 32'(wdog_err), 32'd0);

    // Randomized grants
    for (int t = 0; t < 40; t++) begin
      int sel, hold;
      sel  = $urandom_range(1, 7);
      hold = $urandom_range(1, 6);
      txn(sel[2], sel[1], sel[0], hold, (hold >= 2) && ($urandom_range(0, 2) == 0));
    end
    chk("no_wdog_after_random", 32'(wdog_err), 32'd0);

    // Watchdog: read never ends
    rand_clients();
    exp_q.push_back(expect_for(pick(1'b0, 1'b0, 1'b1)));
    rd_ask = 1'b1;
    @(posedge sclk); #1; rd_ask = 1'b0;
    wd_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sclk);
      if (!rd_en) break;
      wd_cycles++;
    end
    chk("wdog_read_cycles", 32'(wd_cycles), 32'(GRANT_MAX));
    chk("wdog_err_set", 32'(wdog_err), 32'd1);
    $display("txn watchdog read lasted %0d cycles", wd_cycles);
    @(posedge sclk); #1;
    for (int t = 0; t < 3; t++) txn(1'b0, 1'b1, 1'b1, 2, 1'b0);
    chk("wdog_err_sticky", 32'(wdog_err), 32'd1);

    // Reset in the middle of a write grant
    rand_clients();
    exp_q.push_back(expect_for(pick(1'b0, 1'b1, 1'b0)));
    wr_ask = 1'b1;
    @(posedge sclk); #1; wr_ask = 1'b0;
    @(negedge sclk); #1;
    mon_en = 1'b0;
    init_cmd = 4'b0011; init_addr = 12'h5A5;
    dq_oe = 1'b1; dq_val = 16'h5A3C;
    srst_n = 1'b0;
    #1;
    chk("midreset_grants", {29'h0, aref_en, wr_en, rd_en}, 32'h0);
    chk("midreset_pins", {pin_cmd, sdram_bank, sdram_addr}, {4'b0011, 2'b00, 12'h5A5});
    chk("midreset_dq_released", 32'(sdram_dq), 32'h5A3C);
    chk("midreset_wdog_clear", 32'(wdog_err), 32'd0);
    chk("midreset_rd_data", 32'(rd_data), 32'd0);
    dq_oe = 1'b0;
    @(posedge sclk); #1;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
